sess_sched: RTL and testbench
=============================

SESS_SCHED -- requirements
Module: sess_sched

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter TMO, default 15: device-response timeout in cycles (1..15).
REQ-003 SHALL have ports:
 - clk  in  1  sole clock, rising edge.
 - rst  in  1  reset, asynchronous, active-high.
 - req  in  N  per-requester session request, held high for the whole session.
 - d_data  in  8N  per-requester payload byte; requester i uses bits [8i+7:8i].
 - d_valid  in  N  payload byte valid.
 - d_ready  out  N  payload byte accepted.
 - gnt  out  N  one-hot grant.
 - dev_state  in  3  device state: IDLE=000, ON=001, OFF=010, WAIT=100.
 - data_o  out  8  device data byte.
 - en_o  out  1  device enable.
 - err_o  out  1  one-cycle error pulse.
 - fault_o  out  1  sticky timeout fault.
REQ-004 SHALL register every output except d_ready, which is combinational from state, gnt and d_valid.

Function
REQ-005 SHALL run a controller FSM with states S_IDLE, S_OPEN, S_STREAM, S_CLOSE, S_DRAIN.
REQ-006 In S_IDLE with any req high and fault_o low, SHALL grant the requester after the last-granted index in round-robin order (index 0 first after reset), set gnt, and enter S_OPEN.
REQ-007 In S_OPEN, SHALL drive data_o=0x01 and en_o=1 until dev_state==ON, then enter S_STREAM with en_o=0.
REQ-008 In S_STREAM, SHALL assert d_ready only for the granted requester; each accepted byte SHALL appear on data_o exactly one cycle after acceptance, with en_o=0.
REQ-009 In S_STREAM with no byte accepted in a cycle, SHALL drive data_o=0x00 in the next cycle.
REQ-010 In S_STREAM, an accepted payload byte 0xF0 SHALL be consumed but not forwarded; data_o SHALL be 0x00 and err_o SHALL pulse one cycle.
REQ-011 In S_STREAM, when the granted req is low, SHALL accept no further bytes and enter S_CLOSE; a byte accepted in that same cycle SHALL still be forwarded first.
REQ-012 In S_CLOSE, SHALL hold data_o=0xF0 and en_o=0 until dev_state==OFF, then enter S_DRAIN.
REQ-013 In S_DRAIN, SHALL drive en_o=1 and data_o=0x0F until dev_state==WAIT, then hold en_o=0 until dev_state==IDLE, then clear gnt, record the grant index, and return to S_IDLE.
REQ-014 In S_IDLE, SHALL drive data_o=0x0F and en_o=0, so the device cannot leave IDLE.
REQ-015 SHALL keep a 4-bit wait counter, cleared on every state entry and incremented each cycle spent in S_OPEN, S_CLOSE or S_DRAIN.
REQ-016 When the wait counter reaches TMO, SHALL pulse err_o, set fault_o, clear gnt, and return to S_IDLE.
REQ-017 While fault_o is set, SHALL issue no grant; fault_o SHALL clear only on reset.
REQ-018 Changes in req while in S_OPEN, S_CLOSE or S_DRAIN SHALL NOT abort the session; a non-granted req SHALL wait for S_IDLE.
REQ-019 Session-to-session turnaround SHALL be one cycle: S_IDLE to gnt asserted.

Reset
REQ-020 Reset SHALL force: S_IDLE, gnt=0, d_ready=0, data_o=0x0F, en_o=0, err_o=0, fault_o=0, wait counter=0, last-granted index=N-1.
REQ-021 Reset asserted mid-session SHALL abandon the session immediately, with no close sequence issued.

Structure
REQ-022 A shared package sess_pkg SHALL hold the device state codes, the FSM state enum, and the constants OPEN=0x01, IDLE_BYTE=0x0F, CLOSE=0xF0, FILL=0x00.
REQ-023 Round-robin selection SHALL be a sub-module rr_arb (N-bit request, last index in, one-hot grant out).

Verification
REQ-024 Single session: req[1]=1, bytes 0x11,0x22, then req[1]=0, with an ideal device model. Required: data_o shows 0x01, 0x11, 0x22, 0xF0, 0x0F; gnt returns to 0; err_o stays 0.
REQ-025 Round robin: req=4'b1111 held through three sessions. Required: gnt goes 0001, 0010, 0100.
REQ-026 Reserved byte: payload 0xF0 sent mid-stream. Required: d_ready accepts it, data_o=0x00 the next cycle, err_o pulses once, session continues.
REQ-027 Timeout: dev_state stuck at IDLE during S_OPEN. Required: after 15 cycles err_o pulses, fault_o=1, gnt=0, and no further grants until rst.
REQ-028 Reset mid-stream: rst pulsed while in S_STREAM. Required: outputs return to their REQ-020 values asynchronously, and the next grant goes to index 0.

Source files
------------

// File: rtl/sess_pkg.sv
// Shared device codes, controller states and protocol bytes for the session scheduler.
package sess_pkg;

  localparam logic [2:0] DEV_IDLE = 3'b000;
  localparam logic [2:0] DEV_ON   = 3'b001;
  localparam logic [2:0] DEV_OFF  = 3'b010;
  localparam logic [2:0] DEV_WAIT = 3'b100;

  localparam logic [7:0] OPEN      = 8'h01;
  localparam logic [7:0] IDLE_BYTE = 8'h0F;
  localparam logic [7:0] CLOSE     = 8'hF0;
  localparam logic [7:0] FILL      = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPEN,
    S_STREAM,
    S_CLOSE,
    S_DRAIN
  } sess_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: grants the first requester strictly after the last-granted index.
module rr_arb
  import sess_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt
);

  logic [31:0] pos;
  logic        found;

  // Walk offsets 1..N from the last winner, wrapping without a modulo.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 1; k <= N; k++) begin
      pos = 32'(last) + 32'(k);
      if (pos >= 32'(N)) pos = pos - 32'(N);
      if (!found && req[pos[IW-1:0]]) begin
        gnt[pos[IW-1:0]] = 1'b1;
        found            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sess_sched.sv
// Session scheduler: grants one requester at a time and sequences the device
// through open, payload streaming, close and drain.
//
// state    | meaning
// S_IDLE   | no session; park device with IDLE_BYTE, arbitrate on req
// S_OPEN   | drive OPEN with enable until device reports ON
// S_STREAM | forward granted payload bytes with one cycle latency
// S_CLOSE  | hold CLOSE until device reports OFF
// S_DRAIN  | enable with IDLE_BYTE until WAIT, then release until IDLE
module sess_sched
  import sess_pkg::*;
#(
  parameter int N   = 4,
  parameter int TMO = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] d_data,
  input  logic [N-1:0]   d_valid,
  output logic [N-1:0]   d_ready,
  output logic [N-1:0]   gnt,
  input  logic [2:0]     dev_state,
  output logic [7:0]     data_o,
  output logic           en_o,
  output logic           err_o,
  output logic           fault_o
);

  localparam int IW = idx_width(N);

  sess_state_e   state, state_nx;
  logic [N-1:0]  gnt_nx, arb_gnt;
  logic [7:0]    data_nx, sel_byte;
  logic          en_nx, err_nx, fault_nx;
  logic [3:0]    wcnt, wcnt_nx, wcnt_inc;
  logic          drain_rel, drain_rel_nx;
  logic [IW-1:0] last, last_nx, gnt_idx;
  logic          accept, gnt_req, timeout, in_wait;

  rr_arb #(.N(N), .IW(IW)) u_arb (
    .req  (req),
    .last (last),
    .gnt  (arb_gnt)
  );

  assign d_ready  = (state == S_STREAM) ? (gnt & d_valid) : '0;
  assign accept   = |d_ready;
  assign gnt_req  = |(gnt & req);
  assign wcnt_inc = wcnt + 4'd1;
  assign timeout  = (wcnt_inc == 4'(TMO));
  assign in_wait  = (state == S_OPEN) || (state == S_CLOSE) || (state == S_DRAIN);

  always_comb begin
    sel_byte = FILL;
    gnt_idx  = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        sel_byte = sel_byte | d_data[8*i +: 8];
        gnt_idx  = gnt_idx | IW'(i);
      end
    end
  end

  always_comb begin
    state_nx     = state;
    gnt_nx       = gnt;
    data_nx      = data_o;
    en_nx        = en_o;
    err_nx       = 1'b0;
    fault_nx     = fault_o;
    drain_rel_nx = drain_rel;
    last_nx      = last;
    wcnt_nx      = '0;

    case (state)
      S_IDLE: begin
        data_nx = IDLE_BYTE;
        en_nx   = 1'b0;
        if (|req && !fault_o) begin
          gnt_nx   = arb_gnt;
          data_nx  = OPEN;
          en_nx    = 1'b1;
          state_nx = S_OPEN;
        end
      end
      S_OPEN: begin
        data_nx = OPEN;
        en_nx   = 1'b1;
        if (dev_state == DEV_ON) begin
          data_nx  = FILL;
          en_nx    = 1'b0;
          state_nx = S_STREAM;
        end
      end
      S_STREAM: begin
        en_nx = 1'b0;
        // A reserved CLOSE byte is swallowed so the device never sees it mid-session.
        if (accept) begin
          data_nx = (sel_byte == CLOSE) ? FILL : sel_byte;
          err_nx  = (sel_byte == CLOSE);
        end else begin
          data_nx = gnt_req ? FILL : CLOSE;
        end
        if (!gnt_req) state_nx = S_CLOSE;
      end
      S_CLOSE: begin
        data_nx = CLOSE;
        en_nx   = 1'b0;
        if (dev_state == DEV_OFF) begin
          data_nx      = IDLE_BYTE;
          en_nx        = 1'b1;
          drain_rel_nx = 1'b0;
          state_nx     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        data_nx = IDLE_BYTE;
        if (!drain_rel) begin
          en_nx = 1'b1;
          if (dev_state == DEV_WAIT) begin
            drain_rel_nx = 1'b1;
            en_nx        = 1'b0;
          end
        end else begin
          en_nx = 1'b0;
          if (dev_state == DEV_IDLE) begin
            gnt_nx   = '0;
            last_nx  = gnt_idx;
            state_nx = S_IDLE;
          end
        end
      end
      default: begin
        gnt_nx   = '0;
        data_nx  = IDLE_BYTE;
        en_nx    = 1'b0;
        state_nx = S_IDLE;
      end
    endcase

    // Device progress in the same cycle wins over the timeout.
    if (in_wait && (state_nx == state) && timeout) begin
      gnt_nx   = '0;
      data_nx  = IDLE_BYTE;
      en_nx    = 1'b0;
      err_nx   = 1'b1;
      fault_nx = 1'b1;
      state_nx = S_IDLE;
    end

    if (in_wait && (state_nx == state)) wcnt_nx = wcnt_inc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      gnt       <= '0;
      data_o    <= IDLE_BYTE;
      en_o      <= 1'b0;
      err_o     <= 1'b0;
      fault_o   <= 1'b0;
      wcnt      <= '0;
      drain_rel <= 1'b0;
      last      <= IW'(N-1);
    end else begin
      state     <= state_nx;
      gnt       <= gnt_nx;
      data_o    <= data_nx;
      en_o      <= en_nx;
      err_o     <= err_nx;
      fault_o   <= fault_nx;
      wcnt      <= wcnt_nx;
      drain_rel <= drain_rel_nx;
      last      <= last_nx;
    end
  end

endmodule

// File: tb/tb_sess_sched.sv
// Directed bench for sess_sched: ideal device model, stream vector table and
// hand-written sequences for close, timeout and mid-session reset.
`timescale 1ns/1ps
module tb_sess_sched;
  import sess_pkg::*;

  localparam int N   = 4;
  localparam int TMO = 15;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, d_valid, d_ready, gnt;
  logic [8*N-1:0] d_data;
  logic [2:0]     dev_state;
  logic [7:0]     data_o;
  logic           en_o, err_o, fault_o;
  logic           dev_ideal;
  logic           mon_en;
  logic [7:0]     seen[$];
  int             err_seen;
  int             errors = 0;
  int             checks = 0;

  typedef struct {
    logic [N-1:0] valid;
    logic [7:0]   byte_in;
    logic [N-1:0] exp_ready;
    logic [7:0]   exp_data;
    logic         exp_err;
  } vec_t;

  vec_t       vecs[5];
  logic [7:0] exp_seq[5];

  sess_sched #(.N(N), .TMO(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .d_data    (d_data),
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .gnt       (gnt),
    .dev_state (dev_state),
    .data_o    (data_o),
    .en_o      (en_o),
    .err_o     (err_o),
    .fault_o   (fault_o)
  );

  always #5 clk = ~clk;

  // Ideal device: advances only on the command the controller is expected to issue.
  always @(posedge clk or posedge rst) begin
    if (rst) dev_state <= DEV_IDLE;
    else if (dev_ideal) begin
      case (dev_state)
        DEV_IDLE: if (en_o && data_o == OPEN)      dev_state <= DEV_ON;
        DEV_ON:   if (data_o == CLOSE)             dev_state <= DEV_OFF;
        DEV_OFF:  if (en_o && data_o == IDLE_BYTE) dev_state <= DEV_WAIT;
        DEV_WAIT: if (!en_o)                       dev_state <= DEV_IDLE;
        default:                                   dev_state <= DEV_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!mon_en) begin
      err_seen = 0;
      seen.delete();
    end else begin
      if (err_o) err_seen++;
      if (gnt != '0 && data_o != FILL && (seen.size() == 0 || seen[$] != data_o))
        seen.push_back(data_o);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " gnt"},     32'(gnt),     32'h0);
    check({tag, " d_ready"}, 32'(d_ready), 32'h0);
    check({tag, " data_o"},  32'(data_o),  32'h0F);
    check({tag, " en_o"},    32'(en_o),    32'h0);
    check({tag, " err_o"},   32'(err_o),   32'h0);
    check({tag, " fault_o"}, 32'(fault_o), 32'h0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; req = '0; d_valid = '0;
    #1;
    check_reset_vals(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_stream(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(gnt != '0 && !en_o) && n < 40);
    check({tag, " reached stream"}, 32'(gnt != '0 && !en_o), 32'h1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (gnt != '0 && n < 60);
    check({tag, " gnt released"}, 32'(gnt), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [N-1:0] any_gnt;

    vecs[0] = '{4'b1111, 8'h11, 4'b0100, 8'h11, 1'b0};
    vecs[1] = '{4'b1011, 8'h22, 4'b0000, 8'h00, 1'b0};
    vecs[2] = '{4'b0100, 8'hF0, 4'b0100, 8'h00, 1'b1};
    vecs[3] = '{4'b0100, 8'h33, 4'b0100, 8'h33, 1'b0};
    vecs[4] = '{4'b1111, 8'h0F, 4'b0100, 8'h0F, 1'b0};
    exp_seq = '{8'h01, 8'h11, 8'h22, 8'hF0, 8'h0F};

    rst = 1'b0; req = '0; d_valid = '0; d_data = '0;
    dev_ideal = 1'b1; mon_en = 1'b0;

    // Single session on requester 1
    do_reset("reset");
    mon_en = 1'b1;
    @(negedge clk);
    req = 4'b0010;
    @(posedge clk); #1;
    check("A gnt", 32'(gnt), 32'h2);
    check("A open data", 32'(data_o), 32'h01);
    check("A open en", 32'(en_o), 32'h1);
    wait_stream("A");
    d_data = {N{8'h11}}; d_valid = 4'b0010;
    #1 check("A ready 11", 32'(d_ready), 32'h2);
    @(negedge clk);
    check("A data 11", 32'(data_o), 32'h11);
    d_data = {N{8'h22}};
    @(negedge clk);
    check("A data 22", 32'(data_o), 32'h22);
    d_valid = '0; req = '0;
    wait_idle("A");
    #1;
    check("A seq length", 32'(seen.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("A seq[%0d]", i), (i < seen.size()) ? 32'(seen[i]) : 32'hFFFF_FFFF, 32'(exp_seq[i]));
    check("A no err", 32'(err_seen), 32'd0);
    check("A idle data", 32'(data_o), 32'h0F);
    mon_en = 1'b0;

    // Round robin with all requesters active, plus stream table on lane 2
    do_reset("B reset");
    req = 4'b1111;
    @(posedge clk); #1;
    check("B gnt first", 32'(gnt), 32'h1);
    wait_stream("B1");
    req = 4'b1110;
    wait_idle("B1");
    req = 4'b1111;
    @(posedge clk); #1;
    check("B gnt second", 32'(gnt), 32'h2);
    wait_stream("B2");
    req = 4'b1101;
    wait_idle("B2");
    req = 4'b1111;
    @(posedge clk); #1;
    check("B gnt third", 32'(gnt), 32'h4);
    wait_stream("B3");
    for (int i = 0; i < 5; i++) begin
      d_valid = vecs[i].valid;
      d_data  = {N{8'hA5}};
      d_data[8*2 +: 8] = vecs[i].byte_in;
      #1 check($sformatf("B vec%0d d_ready", i), 32'(d_ready), 32'(vecs[i].exp_ready));
      @(negedge clk);
      check($sformatf("B vec%0d data_o", i), 32'(data_o), 32'(vecs[i].exp_data));
      check($sformatf("B vec%0d err_o", i), 32'(err_o), 32'(vecs[i].exp_err));
    end
    // Byte accepted in the cycle the request drops still goes out before CLOSE
    d_valid = 4'b0100;
    d_data[8*2 +: 8] = 8'h44;
    req = 4'b1011;
    #1 check("B final d_ready", 32'(d_ready), 32'h4);
    @(negedge clk);
    check("B final byte", 32'(data_o), 32'h44);
    d_valid = '0;
    @(negedge clk);
    check("B close byte", 32'(data_o), 32'hF0);
    req = '0;
    wait_idle("B3");

    // Reset in the middle of a stream
    req = 4'b1000;
    @(posedge clk); #1;
    check("D gnt", 32'(gnt), 32'h8);
    wait_stream("D");
    d_valid = 4'b1000;
    d_data  = {N{8'h55}};
    @(negedge clk);
    check("D data 55", 32'(data_o), 32'h55);
    #2 rst = 1'b1;
    #1 check_reset_vals("D async reset");
    @(negedge clk);
    rst = 1'b0; d_valid = '0; req = 4'b1111;
    @(posedge clk); #1;
    check("D gnt after reset", 32'(gnt), 32'h1);

    // Device stuck in IDLE during open
    do_reset("C reset");
    dev_ideal = 1'b0;
    req = 4'b0001;
    @(posedge clk); #1;
    check("C gnt", 32'(gnt), 32'h1);
    n = 0;
    while (!err_o && n < 40) begin
      @(posedge clk); n++; #1;
    end
    check("C cycles to err", 32'(n), 32'd15);
    check("C fault set", 32'(fault_o), 32'h1);
    check("C gnt cleared", 32'(gnt), 32'h0);
    check("C en low", 32'(en_o), 32'h0);
    @(posedge clk); #1;
    check("C err single pulse", 32'(err_o), 32'h0);
    req = 4'b1111;
    any_gnt = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      any_gnt = any_gnt | gnt;
    end
    check("C no grant while faulted", 32'(any_gnt), 32'h0);
    check("C fault sticky", 32'(fault_o), 32'h1);
    do_reset("C fault cleared");
    dev_ideal = 1'b1;
    req = 4'b0001;
    @(posedge clk); #1;
    check("C grant after reset", 32'(gnt), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
